// File: rtl/dia_share_arbiter.sv
// -----------------------------------------------------------------------------
// dia_share_arbiter
//
// Round-robin scheduler that shares one diamond-weighting combine datapath
// between two requesters, A and B. Each requester offers three tokens with
// SEND/DATA and consumes them with ACK. At most one requester fires per cycle.
// Its tagged result appears on the OUT_* channel one cycle after the fire.
//
// Parameters
//   DW     token data width. Fixed at 16 because the datapath slices assume it.
//   BURST  maximum consecutive fires for one requester while the other waits
//          (legal range 1..15).
//
// Ports
//   CLK, RESET               rising-edge clock; asynchronous active-low reset
//   A_IN{1,2,3}_SEND/DATA    requester A tokens available / token values
//   A_IN{1,2,3}_ACK          requester A consume strobes (combinational)
//   B_IN{1,2,3}_SEND/DATA    requester B tokens available / token values
//   B_IN{1,2,3}_ACK          requester B consume strobes (combinational)
//   OUT_RDY                  consumer accepts a token in the following cycle
//   OUT_SEND                 result-valid strobe, one cycle after a fire
//   OUT_DATA                 result value. Holds its value while OUT_SEND is 0.
//   OUT_TAG                  result source: 0 = A, 1 = B
//   OUT_COUNT                tokens per send, constant 1
//
// Optional feature
//   DIA_SATURATE_EN  When defined, a weighted sum of 2^14 or more clamps
//                    OUT_DATA to 16'hFFFC. When undefined, the sum wraps
//                    modulo 2^14.
// -----------------------------------------------------------------------------
module dia_share_arbiter #(
  parameter int DW    = 16,
  parameter int BURST = 2
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          A_IN1_SEND,
  input  logic          A_IN2_SEND,
  input  logic          A_IN3_SEND,
  input  logic [DW-1:0] A_IN1_DATA,
  input  logic [DW-1:0] A_IN2_DATA,
  input  logic [DW-1:0] A_IN3_DATA,
  output logic          A_IN1_ACK,
  output logic          A_IN2_ACK,
  output logic          A_IN3_ACK,
  input  logic          B_IN1_SEND,
  input  logic          B_IN2_SEND,
  input  logic          B_IN3_SEND,
  input  logic [DW-1:0] B_IN1_DATA,
  input  logic [DW-1:0] B_IN2_DATA,
  input  logic [DW-1:0] B_IN3_DATA,
  output logic          B_IN1_ACK,
  output logic          B_IN2_ACK,
  output logic          B_IN3_ACK,
  input  logic          OUT_RDY,
  output logic          OUT_SEND,
  output logic [DW-1:0] OUT_DATA,
  output logic          OUT_TAG,
  output logic [15:0]   OUT_COUNT
);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} owner_t;

  localparam logic [3:0] BURST_MAX = 4'(BURST);

  owner_t      owner, owner_nxt;
  logic        last, last_nxt;      // 0 = A was granted most recently, 1 = B
  logic [3:0]  bcnt, bcnt_nxt;
  logic [3:0]  bcnt_inc;
  logic        elig_a, elig_b;
  logic        grant_a, grant_b;
  logic        fire_a, fire_b;

  // A requester is eligible only with all three tokens present. A partial
  // set is never acknowledged.
  assign elig_a = A_IN1_SEND & A_IN2_SEND & A_IN3_SEND;
  assign elig_b = B_IN1_SEND & B_IN2_SEND & B_IN3_SEND;

  assign bcnt_inc = (bcnt >= BURST_MAX) ? BURST_MAX : bcnt + 4'd1;

  // NOTE: every signal driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    owner_nxt = owner;
    bcnt_nxt  = bcnt;
    last_nxt  = last;
    grant_a   = 1'b0;
    grant_b   = 1'b0;

    if (OUT_RDY) begin
      unique case (owner)
        // From IDLE, a tie goes to the requester that was not served last.
        IDLE: begin
          if (elig_a && (!elig_b || last)) grant_a = 1'b1;
          else if (elig_b)                 grant_b = 1'b1;
        end
        // The owner keeps firing until its burst is spent or it runs dry,
        // but only while the other requester is actually waiting.
        OWN_A: begin
          if (elig_b && (!elig_a || bcnt >= BURST_MAX)) grant_b = 1'b1;
          else if (elig_a)                              grant_a = 1'b1;
        end
        OWN_B: begin
          if (elig_a && (!elig_b || bcnt >= BURST_MAX)) grant_a = 1'b1;
          else if (elig_b)                              grant_b = 1'b1;
        end
        default: ;
      endcase
    end

    if (grant_a) begin
      owner_nxt = OWN_A;
      last_nxt  = 1'b0;
      bcnt_nxt  = (owner == OWN_A) ? bcnt_inc : 4'd1;
    end else if (grant_b) begin
      owner_nxt = OWN_B;
      last_nxt  = 1'b1;
      bcnt_nxt  = (owner == OWN_B) ? bcnt_inc : 4'd1;
    end else if (!elig_a && !elig_b) begin
      // One idle cycle with nobody eligible releases ownership. bcnt is held.
      owner_nxt = IDLE;
    end
  end

  // The ACKs are combinational, so they are gated with RESET directly. This
  // keeps them low while RESET is asserted, whatever the SEND inputs do.
  assign fire_a = grant_a & RESET;
  assign fire_b = grant_b & RESET;

  assign A_IN1_ACK = fire_a;
  assign A_IN2_ACK = fire_a;
  assign A_IN3_ACK = fire_a;
  assign B_IN1_ACK = fire_b;
  assign B_IN2_ACK = fire_b;
  assign B_IN3_ACK = fire_b;

  // Shared combine datapath, fed from whichever requester is granted.
  logic [DW-1:0] in1, in2, in3;
  logic [15:0]   sum;
  logic [DW-1:0] result;
  logic          unused_bits;

  assign in1 = fire_b ? B_IN1_DATA : A_IN1_DATA;
  assign in2 = fire_b ? B_IN2_DATA : A_IN2_DATA;
  assign in3 = fire_b ? B_IN3_DATA : A_IN3_DATA;

  // Each term fits in 14 bits, so the 16-bit sum of three terms never
  // overflows. Bits [15:14] therefore show whether the 2^14 range was exceeded.
  assign sum = 16'(in1[13:0]) + 16'({in2[10:0], 3'b000}) + 16'({in3[8:0], 5'b00000});

  // Input bits above the slices do not affect the result.
  assign unused_bits = ^{in1[15:14], in2[15:11], in3[15:9]};

`ifdef DIA_SATURATE_EN
  assign result = (sum[15:14] != 2'b00) ? 16'hFFFC : {sum[13:0], 2'b00};
`else
  assign result = {sum[13:0], 2'b00};
`endif

  // NOTE: sequential state uses non-blocking assignments, so every flop
  // samples values from before the edge, regardless of block order.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      owner    <= IDLE;
      last     <= 1'b1;            // B counts as served, so A has first priority
      bcnt     <= 4'd0;
      OUT_SEND <= 1'b0;
      OUT_DATA <= '0;
      OUT_TAG  <= 1'b0;
    end else begin
      owner    <= owner_nxt;
      last     <= last_nxt;
      bcnt     <= bcnt_nxt;
      OUT_SEND <= fire_a | fire_b;
      if (fire_a | fire_b) begin
        OUT_DATA <= result;
        OUT_TAG  <= fire_b;
      end
    end
  end

  assign OUT_COUNT = 16'h0001;

endmodule

// File: tb/tb_dia_share_arbiter.sv
module tb_dia_share_arbiter;

  logic        CLK;
  logic        RESET;
  logic        A_IN1_SEND, A_IN2_SEND, A_IN3_SEND;
  logic [15:0] A_IN1_DATA, A_IN2_DATA, A_IN3_DATA;
  logic        A_IN1_ACK, A_IN2_ACK, A_IN3_ACK;
  logic        B_IN1_SEND, B_IN2_SEND, B_IN3_SEND;
  logic [15:0] B_IN1_DATA, B_IN2_DATA, B_IN3_DATA;
  logic        B_IN1_ACK, B_IN2_ACK, B_IN3_ACK;
  logic        OUT_RDY;
  logic        OUT_SEND;
  logic [15:0] OUT_DATA;
  logic        OUT_TAG;
  logic [15:0] OUT_COUNT;

  dia_share_arbiter #(.DW(16), .BURST(2)) dut (
    .CLK(CLK), .RESET(RESET),
    .A_IN1_SEND(A_IN1_SEND), .A_IN2_SEND(A_IN2_SEND), .A_IN3_SEND(A_IN3_SEND),
    .A_IN1_DATA(A_IN1_DATA), .A_IN2_DATA(A_IN2_DATA), .A_IN3_DATA(A_IN3_DATA),
    .A_IN1_ACK(A_IN1_ACK), .A_IN2_ACK(A_IN2_ACK), .A_IN3_ACK(A_IN3_ACK),
    .B_IN1_SEND(B_IN1_SEND), .B_IN2_SEND(B_IN2_SEND), .B_IN3_SEND(B_IN3_SEND),
    .B_IN1_DATA(B_IN1_DATA), .B_IN2_DATA(B_IN2_DATA), .B_IN3_DATA(B_IN3_DATA),
    .B_IN1_ACK(B_IN1_ACK), .B_IN2_ACK(B_IN2_ACK), .B_IN3_ACK(B_IN3_ACK),
    .OUT_RDY(OUT_RDY), .OUT_SEND(OUT_SEND), .OUT_DATA(OUT_DATA),
    .OUT_TAG(OUT_TAG), .OUT_COUNT(OUT_COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Hand-computed results. A tokens 1/2/3 give 1+16+96 = 113, and 113<<2 = 0x01C4.
  // B tokens 4/5/6 give 4+40+192 = 236, and 236<<2 = 0x03B0. The wrap case
  // 3FFF+0+32 = 0x401F wraps to 0x1F, giving 0x007C, or saturates to 0xFFFC.
  localparam logic [15:0] D_A = 16'h01C4;
  localparam logic [15:0] D_B = 16'h03B0;
`ifdef DIA_SATURATE_EN
  localparam logic [15:0] D_W = 16'hFFFC;
`else
  localparam logic [15:0] D_W = 16'h007C;
`endif

  typedef struct {
    logic [2:0]  a_send;
    logic [2:0]  b_send;
    logic [15:0] a1, a2, a3;
    logic        rdy;
    logic        ack_a, ack_b;   // expected during the cycle
    logic        send, tag;      // expected after the edge
    logic [15:0] data;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;
  vec_t vecs[26];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] as, input logic [2:0] bs, input logic wrap,
                              input logic rdy, input logic aa, input logic ab,
                              input logic snd, input logic tg, input logic [15:0] d);
    vec_t v;
    v.a_send = as; v.b_send = bs; v.rdy = rdy;
    v.a1 = wrap ? 16'hFFFF : 16'd1;
    v.a2 = wrap ? 16'd0    : 16'd2;
    v.a3 = wrap ? 16'd1    : 16'd3;
    v.ack_a = aa; v.ack_b = ab; v.send = snd; v.tag = tg; v.data = d;
    return v;
  endfunction

  task automatic drive(input logic [2:0] as, input logic [2:0] bs, input logic rdy);
    {A_IN3_SEND, A_IN2_SEND, A_IN1_SEND} = as;
    {B_IN3_SEND, B_IN2_SEND, B_IN1_SEND} = bs;
    OUT_RDY = rdy;
  endtask

  task automatic check_acks(input string name, input logic aa, input logic ab);
    check({name, ".ack_a"}, {13'd0, A_IN3_ACK, A_IN2_ACK, A_IN1_ACK}, {13'd0, {3{aa}}});
    check({name, ".ack_b"}, {13'd0, B_IN3_ACK, B_IN2_ACK, B_IN1_ACK}, {13'd0, {3{ab}}});
  endtask

  task automatic check_out(input string name, input logic snd, input logic tg, input logic [15:0] d);
    check({name, ".send"}, {15'd0, OUT_SEND}, {15'd0, snd});
    check({name, ".tag"},  {15'd0, OUT_TAG},  {15'd0, tg});
    check({name, ".data"}, OUT_DATA, d);
  endtask

  initial begin
    // Vector table: inputs for one cycle, the ACKs expected in that cycle,
    // and the outputs expected after the edge.
    //            a_send  b_send  wrap rdy  ackA ackB send tag data
    vecs[0]  = mk(3'b111, 3'b000, 0, 1,   1, 0,   1, 0, D_A);  // single fire A
    vecs[1]  = mk(3'b000, 3'b000, 0, 1,   0, 0,   0, 0, D_A);
    vecs[2]  = mk(3'b000, 3'b000, 0, 1,   0, 0,   0, 0, D_A);
    vecs[3]  = mk(3'b111, 3'b000, 1, 1,   1, 0,   1, 0, D_W);  // wrap/saturate
    vecs[4]  = mk(3'b000, 3'b000, 0, 1,   0, 0,   0, 0, D_W);
    vecs[5]  = mk(3'b000, 3'b000, 0, 1,   0, 0,   0, 0, D_W);
    vecs[6]  = mk(3'b000, 3'b011, 0, 1,   0, 0,   0, 0, D_W);  // B_IN3 missing
    vecs[7]  = mk(3'b000, 3'b111, 0, 0,   0, 0,   0, 0, D_W);  // backpressure
    vecs[8]  = mk(3'b000, 3'b111, 0, 0,   0, 0,   0, 0, D_W);
    vecs[9]  = mk(3'b000, 3'b111, 0, 0,   0, 0,   0, 0, D_W);
    vecs[10] = mk(3'b000, 3'b111, 0, 1,   0, 1,   1, 1, D_B);  // RDY rises
    vecs[11] = mk(3'b000, 3'b000, 0, 1,   0, 0,   0, 1, D_B);
    vecs[12] = mk(3'b000, 3'b000, 0, 1,   0, 0,   0, 1, D_B);
    vecs[13] = mk(3'b111, 3'b111, 0, 1,   1, 0,   1, 0, D_A);  // burst A A B B A A
    vecs[14] = mk(3'b111, 3'b111, 0, 1,   1, 0,   1, 0, D_A);
    vecs[15] = mk(3'b111, 3'b111, 0, 1,   0, 1,   1, 1, D_B);
    vecs[16] = mk(3'b111, 3'b111, 0, 1,   0, 1,   1, 1, D_B);
    vecs[17] = mk(3'b111, 3'b111, 0, 1,   1, 0,   1, 0, D_A);
    vecs[18] = mk(3'b111, 3'b111, 0, 1,   1, 0,   1, 0, D_A);
    vecs[19] = mk(3'b101, 3'b111, 0, 1,   0, 1,   1, 1, D_B);  // A partial: no partial ACK
    vecs[20] = mk(3'b111, 3'b110, 0, 1,   1, 0,   1, 0, D_A);  // owner B not eligible
    vecs[21] = mk(3'b111, 3'b111, 0, 0,   0, 0,   0, 0, D_A);  // RDY low holds bcnt
    vecs[22] = mk(3'b111, 3'b111, 0, 1,   1, 0,   1, 0, D_A);
    vecs[23] = mk(3'b111, 3'b111, 0, 1,   0, 1,   1, 1, D_B);
    vecs[24] = mk(3'b000, 3'b000, 0, 1,   0, 0,   0, 1, D_B);
    vecs[25] = mk(3'b000, 3'b000, 0, 1,   0, 0,   0, 1, D_B);

    B_IN1_DATA = 16'd4; B_IN2_DATA = 16'd5; B_IN3_DATA = 16'd6;
    A_IN1_DATA = 16'd1; A_IN2_DATA = 16'd2; A_IN3_DATA = 16'd3;

    // Reset: ACKs stay low even with both requesters eligible and RDY high.
    RESET = 1'b0;
    drive(3'b111, 3'b111, 1'b1);
    #2;
    check_acks("reset", 1'b0, 1'b0);
    check_out("reset", 1'b0, 1'b0, 16'h0000);
    check("reset.count", OUT_COUNT, 16'h0001);
    @(negedge CLK);
    drive(3'b000, 3'b000, 1'b1);
    RESET = 1'b1;

    for (int i = 0; i < 26; i++) begin
      @(negedge CLK);
      drive(vecs[i].a_send, vecs[i].b_send, vecs[i].rdy);
      A_IN1_DATA = vecs[i].a1; A_IN2_DATA = vecs[i].a2; A_IN3_DATA = vecs[i].a3;
      #1;
      check_acks($sformatf("vec%0d", i), vecs[i].ack_a, vecs[i].ack_b);
      @(posedge CLK);
      #1;
      check_out($sformatf("vec%0d", i), vecs[i].send, vecs[i].tag, vecs[i].data);
      if (i == 0) check("vec0.count", OUT_COUNT, 16'h0001);
    end

    // Async reset in the cycle after a fire. The A fire leaves last = A,
    // so A winning the first tie after release shows that last was reset to B.
    @(negedge CLK);
    drive(3'b111, 3'b000, 1'b1);
    A_IN1_DATA = 16'd1; A_IN2_DATA = 16'd2; A_IN3_DATA = 16'd3;
    @(posedge CLK);
    #1;
    check_out("rst_fire", 1'b1, 1'b0, D_A);
    drive(3'b111, 3'b111, 1'b1);
    #2;
    RESET = 1'b0;
    #1;
    check_out("rst_async", 1'b0, 1'b0, 16'h0000);
    check_acks("rst_async", 1'b0, 1'b0);
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    check_acks("rst_release", 1'b1, 1'b0);
    @(posedge CLK);
    #1;
    check_out("rst_release", 1'b1, 1'b0, D_A);

    @(negedge CLK);
    drive(3'b000, 3'b000, 1'b0);
    @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
